// File: rtl/data_memory_unit.sv
// Multi-cycle byte-addressable load/store data memory with a fixed response
// latency, plus the combinational branch-select used by the fetch stage.
module data_memory_unit #(
  parameter int WORD_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic              zero,
  input  logic              branch,
  input  logic              uncondbranch,
  output logic              resp_valid,
  output logic [WORD_W-1:0] read_data,
  output logic              resp_error,
  output logic              pc_src
);
  localparam int BYTES = WORD_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  logic [WORD_W-1:0] mem_r [DEPTH];

  logic [1:0]        state_r;
  logic [2:0]        cnt_r;
  logic              ready_r;
  logic              resp_valid_r;
  logic              resp_error_r;
  logic [WORD_W-1:0] read_data_r;
  logic [WORD_W-1:0] addr_r;
  logic [WORD_W-1:0] wdata_r;
  logic              read_r;
  logic              write_r;
  logic [1:0]        size_r;
  logic              sext_r;

  logic              accept_s;
  logic              enter_resp_s;
  logic [1:0]        next_state_s;
  logic [2:0]        next_cnt_s;
  logic [WORD_W-1:0] cur_addr_s;
  logic [WORD_W-1:0] cur_wdata_s;
  logic              cur_read_s;
  logic              cur_write_s;
  logic [1:0]        cur_size_s;
  logic              cur_sext_s;
  logic [OFF_W-1:0]  lane_s;
  logic [IDX_W-1:0]  idx_s;
  logic              misalign_s;
  logic              error_s;
  logic [6:0]        shamt_s;
  logic [BYTES-1:0]  size_mask_s;
  logic [BYTES-1:0]  byte_en_s;
  logic [WORD_W-1:0] word_s;
  logic [WORD_W-1:0] shifted_s;
  logic [WORD_W-1:0] aligned_s;
  logic [WORD_W-1:0] load_s;
  logic [WORD_W-1:0] wsh_s;
  logic [WORD_W-1:0] merged_s;

  assign pc_src     = uncondbranch | (branch & zero);
  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_error = resp_error_r;
  assign read_data  = read_data_r;

  assign accept_s = (state_r == IDLE) && req_valid && (mem_read || mem_write);

  // With LATENCY=1 the operation completes on the acceptance edge, so the live inputs are used in IDLE.
  always_comb begin
    if (state_r == IDLE) begin
      cur_addr_s  = address;
      cur_wdata_s = write_data;
      cur_read_s  = mem_read;
      cur_write_s = mem_write;
      cur_size_s  = size;
      cur_sext_s  = sign_ext;
    end else begin
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_read_s  = read_r;
      cur_write_s = write_r;
      cur_size_s  = size_r;
      cur_sext_s  = sext_r;
    end
  end

  // Address decode, size-dependent masks and request error classification.
  always_comb begin
    lane_s      = cur_addr_s[OFF_W-1:0];
    idx_s       = cur_addr_s[OFF_W +: IDX_W];
    misalign_s  = 1'b0;
    shamt_s     = 7'd0;
    size_mask_s = BYTES'(8'hff);
    case (cur_size_s)
      2'b00: begin
        misalign_s  = 1'b0;
        shamt_s     = 7'(WORD_W - 8);
        size_mask_s = BYTES'(8'h01);
      end
      2'b01: begin
        misalign_s  = cur_addr_s[0];
        shamt_s     = 7'(WORD_W - 16);
        size_mask_s = BYTES'(8'h03);
      end
      2'b10: begin
        misalign_s  = |cur_addr_s[1:0];
        shamt_s     = 7'(WORD_W - 32);
        size_mask_s = BYTES'(8'h0f);
      end
      2'b11: begin
        misalign_s  = |cur_addr_s[2:0];
        shamt_s     = 7'd0;
        size_mask_s = BYTES'(8'hff);
      end
      default: begin
        misalign_s  = 1'b0;
        shamt_s     = 7'd0;
        size_mask_s = BYTES'(8'hff);
      end
    endcase
    byte_en_s = size_mask_s << lane_s;
    error_s   = (cur_read_s && cur_write_s) || misalign_s ||
                ((cur_size_s == 2'b11) && (WORD_W == 32)) ||
                ((cur_addr_s >> OFF_W) >= WORD_W'(DEPTH));
  end

  // Load extraction: move the addressed lane to bit 0, then extend through a left/right shift pair.
  always_comb begin
    word_s    = mem_r[idx_s];
    shifted_s = word_s >> {lane_s, 3'b000};
    aligned_s = shifted_s << shamt_s;
    if (cur_sext_s) begin
      load_s = $signed(aligned_s) >>> shamt_s;
    end else begin
      load_s = aligned_s >> shamt_s;
    end
  end

  // Store merge: only the enabled byte lanes take the shifted write data.
  always_comb begin
    wsh_s    = cur_wdata_s << {lane_s, 3'b000};
    merged_s = word_s;
    for (int b = 0; b < BYTES; b++) begin
      if (byte_en_s[b]) begin
        merged_s[b*8 +: 8] = wsh_s[b*8 +: 8];
      end else begin
        merged_s[b*8 +: 8] = word_s[b*8 +: 8];
      end
    end
  end

  // Next-state and latency counter logic.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_cnt_s = CNT_LOAD;
          if (LATENCY == 1) begin
            next_state_s = RESP;
            enter_resp_s = 1'b1;
          end else begin
            next_state_s = BUSY;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r <= 3'd1) begin
          next_state_s = RESP;
          next_cnt_s   = 3'd0;
          enter_resp_s = 1'b1;
        end else begin
          next_cnt_s = cnt_r - 3'd1;
        end
      end
      RESP: next_state_s = IDLE;
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = 3'd0;
      end
    endcase
  end

  // Control state, request capture and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      read_data_r  <= {WORD_W{1'b0}};
      addr_r       <= {WORD_W{1'b0}};
      wdata_r      <= {WORD_W{1'b0}};
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      size_r       <= 2'b00;
      sext_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= next_cnt_s;
      ready_r      <= (next_state_s == IDLE);
      resp_valid_r <= enter_resp_s;
      resp_error_r <= enter_resp_s && error_s;
      if (enter_resp_s && error_s) begin
        read_data_r <= {WORD_W{1'b0}};
      end else if (enter_resp_s && cur_read_s) begin
        read_data_r <= load_s;
      end
      if (accept_s) begin
        addr_r  <= address;
        wdata_r <= write_data;
        read_r  <= mem_read;
        write_r <= mem_write;
        size_r  <= size;
        sext_r  <= sign_ext;
      end
    end
  end

  // Memory array is not reset; a store commits only on an un-reset edge entering RESP.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp_s && cur_write_s && !error_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed and randomized bench for data_memory_unit, checked against a
// byte-array reference model of the memory and its request rules.
module tb_data_memory_unit;
  logic        clk;
  logic        reset;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic [63:0] address, write_data;
  logic        mem_read, mem_write, sign_ext;
  logic [1:0]  size;
  logic        zero, branch, uncondbranch;
  logic        rv0, rv1, err0, err1, pc0, pc1;
  logic [63:0] rd0, rd1;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  mem_m [2048];
  logic [63:0] last_rd = 64'd0;
  logic [63:0] d1 [6];
  logic [63:0] obs;
  int          cnt;

  data_memory_unit #(.WORD_W(64), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0),
    .address(address), .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .zero(zero),
    .branch(branch), .uncondbranch(uncondbranch), .resp_valid(rv0),
    .read_data(rd0), .resp_error(err0), .pc_src(pc0));

  data_memory_unit #(.WORD_W(64), .DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .address(address), .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .zero(zero),
    .branch(branch), .uncondbranch(uncondbranch), .resp_valid(rv1),
    .read_data(rd1), .resp_error(err1), .pc_src(pc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  // Reference model: 2048-byte memory, little-endian, entries of 8 bytes.
  task automatic model_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic e, output logic [63:0] d);
    int n;
    n = 1 << sz;
    e = (rd && wr) || ((a % 64'(n)) != 64'd0) || (a >= 64'd2048);
    d = 64'd0;
    if (e) begin
      last_rd = 64'd0;
    end else if (rd) begin
      for (int i = 0; i < n; i++) d = d | (64'(mem_m[a + 64'(i)]) << (8 * i));
      if (sx && (n < 8) && d[8*n-1]) d = d | ~((64'd1 << (8 * n)) - 64'd1);
      last_rd = d;
    end else begin
      for (int i = 0; i < n; i++) mem_m[a + 64'(i)] = 8'(wd >> (8 * i));
      d = last_rd;
    end
  endtask

  task automatic xact(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sx, input logic [63:0] a, input logic [63:0] wd,
                      output logic [63:0] o);
    logic        exp_e;
    logic [63:0] exp_d;
    int          lat;
    model_op(rd, wr, sz, sx, a, wd, exp_e, exp_d);
    @(negedge clk);
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
    address = a; write_data = wd; valid0 = 1'b1;
    check({tag, " ready"}, 64'(ready0), 64'd1);
    @(negedge clk);
    valid0 = 1'b0;
    // scramble fields: the unit must work from what it captured
    address = {$urandom, $urandom}; write_data = {$urandom, $urandom};
    mem_read = ~rd; mem_write = ~wr; size = ~sz; sign_ext = ~sx;
    lat = 1;
    while (rv0 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd2);
    check({tag, " error"}, 64'(err0), 64'(exp_e));
    check({tag, " data"}, rd0, exp_d);
    o = rd0;
    @(negedge clk);
    check({tag, " strobe"}, 64'(rv0), 64'd0);
  endtask

  initial begin
    valid0 = 1'b0; valid1 = 1'b0;
    address = 64'd0; write_data = 64'd0; mem_read = 1'b0; mem_write = 1'b0;
    size = 2'b00; sign_ext = 1'b0; zero = 1'b0; branch = 1'b0; uncondbranch = 1'b0;

    // Reset with a simultaneous request: reset wins, nothing is accepted.
    reset = 1'b1;
    valid0 = 1'b1; mem_write = 1'b1; size = 2'b11; address = 64'h10; write_data = 64'hffff;
    repeat (3) @(negedge clk);
    check("rst ready", 64'(ready0), 64'd1);
    check("rst rv", 64'(rv0), 64'd0);
    reset = 1'b0; valid0 = 1'b0; mem_write = 1'b0;
    check("rst rdata", rd0, 64'd0);
    check("rst err", 64'(err0), 64'd0);
    cnt = 0;
    repeat (4) begin @(negedge clk); cnt += int'(rv0); end
    check("rst no resp", 64'(cnt), 64'd0);

    // Branch select truth table.
    for (int c = 0; c < 8; c++) begin
      logic [2:0] bits;
      bits = 3'(c);
      {branch, zero, uncondbranch} = bits;
      #1;
      check("pc_src", 64'(pc0), 64'(bits[0] | (bits[2] & bits[1])));
      check("pc_src1", 64'(pc1), 64'(bits[0] | (bits[2] & bits[1])));
    end

    // Directed store/load sequence.
    xact("st64", 1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, obs);
    xact("ld64", 1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, obs);
    check("ld64 const", obs, 64'h1122334455667788);
    xact("st8", 1'b0, 1'b1, 2'b00, 1'b0, 64'h13, 64'h5a5a5a5a5a5a5aab, obs);
    xact("ld8s", 1'b1, 1'b0, 2'b00, 1'b1, 64'h13, 64'h0, obs);
    check("ld8s const", obs, 64'hffffffffffffffab);
    xact("ld64b", 1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, obs);
    check("ld64b const", obs, 64'h11223344ab667788);

    // Error cases.
    xact("ld16 mis", 1'b1, 1'b0, 2'b01, 1'b0, 64'h11, 64'h0, obs);
    check("ld16 mis const", obs, 64'd0);
    xact("rdwr", 1'b1, 1'b1, 2'b11, 1'b0, 64'h10, 64'hcafef00dcafef00d, obs);
    xact("ld after rdwr", 1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, obs);
    check("unchanged", obs, 64'h11223344ab667788);
    xact("oob", 1'b1, 1'b0, 2'b11, 1'b0, 64'd2048, 64'h0, obs);

    // Request with no operation is ignored.
    @(negedge clk);
    valid0 = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = 64'h10;
    cnt = 0;
    repeat (4) begin @(negedge clk); cnt += int'(rv0); end
    check("nop ready", 64'(ready0), 64'd1);
    check("nop no resp", 64'(cnt), 64'd0);
    valid0 = 1'b0;

    // Reset during BUSY aborts a store.
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; size = 2'b11; address = 64'h10;
    write_data = 64'hdeadbeefdeadbeef; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    check("busy ready", 64'(ready0), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_write = 1'b0;
    last_rd = 64'd0;
    check("abort ready", 64'(ready0), 64'd1);
    check("abort rdata", rd0, 64'd0);
    cnt = int'(rv0);
    repeat (4) begin @(negedge clk); cnt += int'(rv0); end
    check("abort no resp", 64'(cnt), 64'd0);
    xact("ld old", 1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, obs);
    check("ld old const", obs, 64'h11223344ab667788);

    // LATENCY=1 instance: back-to-back stores then loads with valid held high.
    @(negedge clk);
    valid1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int e;
      e = i % 6;
      if (i < 6) d1[e] = {$urandom, $urandom};
      mem_read = (i >= 6); mem_write = (i < 6); size = 2'b11; sign_ext = 1'b0;
      address = 64'(e * 8); write_data = d1[e];
      check("l1 ready", 64'(ready1), 64'd1);
      check("l1 idle rv", 64'(rv1), 64'd0);
      @(negedge clk);
      check("l1 busy", 64'(ready1), 64'd0);
      check("l1 rv", 64'(rv1), 64'd1);
      check("l1 err", 64'(err1), 64'd0);
      if (i >= 6) check("l1 data", rd1, d1[e]);
      @(negedge clk);
    end
    valid1 = 1'b0;

    // Randomized phase over the first 32 entries plus out-of-range addresses.
    for (int e = 0; e < 32; e++)
      xact("init", 1'b0, 1'b1, 2'b11, 1'b0, 64'(e * 8), {$urandom, $urandom}, obs);
    for (int k = 0; k < 150; k++) begin
      logic [1:0]  sz;
      logic [63:0] a;
      logic        rd, wr;
      int          sel;
      sz  = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      rd  = (sel == 0) || (sel >= 5);
      wr  = (sel <= 4);
      if ($urandom_range(0, 9) == 0) a = 64'd2048 + 64'($urandom_range(0, 100000));
      else a = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a = a & ~(64'((1 << sz) - 1));
      xact("rand", rd, wr, sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, obs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Parameters
REQ-001 SHALL provide WORD_W, default 64: data width in bits; legal values 32 or 64.
REQ-002 SHALL provide DEPTH, default 256: number of WORD_W-bit entries; power of two.
REQ-003 SHALL provide LATENCY, default 2: cycles from request acceptance to response; legal range 1..7.

Interface
REQ-004 SHALL have clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have req_valid  input  1: request present.
REQ-007 SHALL have req_ready  output  1: unit can accept a request.
REQ-008 SHALL have address  input  WORD_W: byte address.
REQ-009 SHALL have write_data  input  WORD_W: store data, right-aligned.
REQ-010 SHALL have mem_read  input  1, and mem_write  input  1: operation select.
REQ-011 SHALL have size  input  2: access size; 00 byte, 01 half, 10 32-bit, 11 64-bit.
REQ-012 SHALL have sign_ext  input  1: sign-extend load result.
REQ-013 SHALL have zero  input  1, branch  input  1, and uncondbranch  input  1: branch resolution inputs.
REQ-014 SHALL have resp_valid  output  1: one-cycle response strobe.
REQ-015 SHALL have read_data  output  WORD_W: load result.
REQ-016 SHALL have resp_error  output  1: failed request; valid with resp_valid.
REQ-017 SHALL have pc_src  output  1: branch-taken select.

Function
REQ-018 pc_src SHALL be combinational: uncondbranch OR (branch AND zero); it is independent of the state machine.
REQ-019 The FSM SHALL have states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, req_valid=1 SHALL trigger acceptance: capture all request fields, load the counter with LATENCY-1, and move to RESP if LATENCY=1, otherwise to BUSY.
REQ-021 In IDLE, req_valid=1 with mem_read=0 and mem_write=0 SHALL be ignored; the unit stays in IDLE, req_ready stays 1, and no response is produced.
REQ-022 BUSY SHALL decrement the counter each cycle and move to RESP when the counter reaches 1.
REQ-023 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; response latency is exactly LATENCY cycles after the acceptance edge.
REQ-024 Error SHALL be flagged for any of: both mem_read and mem_write set; address not aligned to the access size; size=11 when WORD_W=32; entry index >= DEPTH.
REQ-025 On error, no memory entry SHALL change, read_data SHALL be 0, and resp_error SHALL be 1.
REQ-026 Entry index SHALL be address >> log2(WORD_W/8); the byte lane SHALL be taken from the low address bits.
REQ-027 A store SHALL update only the addressed bytes, using the low bytes of write_data; it SHALL commit on the edge that enters RESP.
REQ-028 A load SHALL extract the addressed bytes, then zero-extend or sign-extend them (per sign_ext) to WORD_W; read_data SHALL be updated on entry to RESP.
REQ-029 read_data SHALL hold its value until the next load response or reset; a store response SHALL leave read_data unchanged.
REQ-030 Request inputs outside IDLE SHALL be ignored; the captured fields SHALL be used for the whole operation.
REQ-031 A load following a store to the same entry SHALL return the newly stored data.

Reset
REQ-032 Reset SHALL set the state to IDLE and the counter to 0, with req_ready=1, resp_valid=0, resp_error=0 and read_data=0.
REQ-033 Reset SHALL NOT clear the memory array.
REQ-034 Reset asserted in BUSY or RESP SHALL abort the operation: no response is produced, and a pending store not yet committed SHALL be discarded.
REQ-035 Reset SHALL take priority over a simultaneous req_valid.

Verification
REQ-036 With WORD_W=64 and LATENCY=2: store 64-bit 0x1122334455667788 at address 0x10, then load 64-bit from 0x10 -> resp_valid exactly 2 cycles after each acceptance, read_data=0x1122334455667788, resp_error=0.
REQ-037 Following REQ-036: store byte 0xAB at 0x13, then load byte at 0x13 with sign_ext=1 -> read_data=0xFFFFFFFFFFFFFFAB; load 64-bit at 0x10 -> 0x11223344AB667788.
REQ-038 Error cases: load half at 0x11 -> resp_error=1 and read_data=0; mem_read=mem_write=1 -> resp_error=1 and memory unchanged; address=DEPTH*8 -> resp_error=1.
REQ-039 With LATENCY=1, issue back-to-back requests -> req_ready=0 for exactly 1 cycle after each acceptance, and exactly one resp_valid per request.
REQ-040 Accept a store, then assert reset in BUSY -> no resp_valid, req_ready=1 next cycle, and a later load returns the old data.
REQ-041 Sweep all 8 combinations of branch, zero and uncondbranch -> pc_src=1 only for uncondbranch=1 or (branch=1 and zero=1).
